watch_dp: RTL and testbench
===========================

Name: watch_dp

Overview:
- Time-keeping datapath on the consumer side of the watch control unit's adjust-tick interface.
- Free-runs a centisecond/second/minute/hour clock from the system clock.
- Applies the one-cycle up/down adjust pulses (tick_sec_u … tick_hour_d) from the control unit to the matching field.
- Registered time fields feed the FND display formatter.

Parameters:
FCOUNT, 1_000_000, system-clock cycles per centisecond tick (100 MHz -> 100 Hz)
HOUR_INIT, 12, hour value loaded on reset (0..23)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-low
i_run  input  1  1 = time advances; 0 = prescaler and counters frozen (adjust still honoured)
tick_sec_u  input  1  one-cycle pulse: second +1
tick_sec_d  input  1  one-cycle pulse: second -1
tick_min_u  input  1  one-cycle pulse: minute +1
tick_min_d  input  1  one-cycle pulse: minute -1
tick_hour_u  input  1  one-cycle pulse: hour +1
tick_hour_d  input  1  one-cycle pulse: hour -1
o_msec  output  7  centiseconds 0..99
o_sec  output  6  seconds 0..59
o_min  output  6  minutes 0..59
o_hour  output  5  hours 0..23

Behaviour:
- Reset (rst low, async):
  - Prescaler = 0.
  - o_msec, o_sec and o_min = 0.
  - o_hour = HOUR_INIT.
  - Internal tick = 0.
- Prescaler:
  - Counts 0..FCOUNT-1 while i_run=1.
  - At FCOUNT-1 it wraps to 0 and asserts the internal tick for exactly one cycle.
  - While i_run=0 it holds its value (no clear), so resuming continues the partial period.
- Chain: msec mod 100 -> sec mod 60 -> min mod 60 -> hour mod 24.
  - Each field emits carry-out combinationally when it holds max and has carry-in.
  - Carry ripples in the same cycle, e.g. 23:59:59.99 + tick -> 00:00:00.00 on one edge.
- All outputs are registered. A field updates on the clk edge that samples its tick/carry: latency is 1 cycle from the pulse to the visible output.
- Adjust rules per field (sec/min/hour):
  - up only -> +1 mod N.
  - down only -> -1 mod N (0 -> N-1).
  - up and down together -> no adjust.
  - Adjust never generates carry or borrow into the next field: 59 + up -> 0 with minutes unchanged.
  - Adjust does not touch o_msec or the prescaler.
- Simultaneous adjust and carry-in on the same field, same cycle:
  - The adjust wins and that carry-in is dropped.
  - That field's carry-out to higher fields is also suppressed.
  - Net: exactly one step of change per field per cycle.
- Widths: each field is held in its own width. Next values are computed by compare-to-max / compare-to-zero, never by a modulo operator.
- Reset mid-operation: all fields return to their reset values immediately; pulses arriving during reset are ignored.

Optional Feature:
- Macro WATCH_H12_EN.
- Defined:
  - Adds output o_pm (1 bit): 1 when the internal hour >= 12.
  - o_hour is presented in 12-hour form: 0 -> 12, 13..23 -> 1..11, 1..12 unchanged.
  - The internal count remains 0..23; adjust and carry rules are unchanged.
- Not defined: no o_pm port; o_hour = internal 0..23 value.

Decomposition:
- Package watch_pkg holds:
  - Moduli MSEC_MOD=100, SEC_MOD=60, MIN_MOD=60, HOUR_MOD=24.
  - Widths MSEC_W=7, SEC_W=6, MIN_W=6, HOUR_W=5.
  - Default FCOUNT.
- Sub-module watch_field_cnt (parameters MOD, W, INIT). Ports: clk, rst, i_carry, i_up, i_down, o_val, o_carry. It implements the adjust-priority rule once and is instantiated 4 times; the msec instance has up/down tied 0.
- Prescaler stays inline.

Test Plan:
1. FCOUNT=4, rst low then high, i_run=1, 400 cycles -> o_msec steps every 4 cycles, reaches 99 then 0, and o_sec becomes 1 exactly on that edge.
2. Preload via adjusts to 23:59:59, run until o_msec=99 plus one tick -> 00:00:00.00 on a single edge, no intermediate values visible.
3. o_sec=59, pulse tick_sec_u -> o_sec=0 next cycle, o_min unchanged; o_hour=0, pulse tick_hour_d -> o_hour=23.
4. tick_min_u and tick_min_d both high for 1 cycle -> o_min unchanged. tick_sec_d in the same cycle as the msec 99->0 carry, with o_sec=10 -> o_sec=9 and o_min unchanged.
5. i_run=0 mid-period (prescaler=2), hold 50 cycles -> outputs frozen. i_run=1 -> next tick after 2 cycles. Assert rst mid-count -> outputs immediately 0/0/0/HOUR_INIT asynchronously.
6. WATCH_H12_EN defined: hour 0 -> o_hour=12, o_pm=0; hour 13 -> o_hour=1, o_pm=1; hour 12 -> o_hour=12, o_pm=1.

Source files
------------

// File: rtl/watch_pkg.sv
// watch_pkg: moduli, field widths and default prescale count shared by the watch datapath
package watch_pkg;
    localparam int MSEC_MOD   = 100;
    localparam int SEC_MOD    = 60;
    localparam int MIN_MOD    = 60;
    localparam int HOUR_MOD   = 24;
    localparam int MSEC_W     = 7;
    localparam int SEC_W      = 6;
    localparam int MIN_W      = 6;
    localparam int HOUR_W     = 5;
    localparam int FCOUNT_DEF = 1_000_000;
endpackage

// File: rtl/watch_dp_if.sv
// watch_dp_if: run/adjust pulses into the watch datapath and time fields out; master = control/display side, slave = datapath; o_pm only with WATCH_H12_EN
interface watch_dp_if;
    import watch_pkg::*;
    logic              i_run;
    logic              tick_sec_u;
    logic              tick_sec_d;
    logic              tick_min_u;
    logic              tick_min_d;
    logic              tick_hour_u;
    logic              tick_hour_d;
    logic [MSEC_W-1:0] o_msec;
    logic [SEC_W-1:0]  o_sec;
    logic [MIN_W-1:0]  o_min;
    logic [HOUR_W-1:0] o_hour;
`ifdef WATCH_H12_EN
    logic              o_pm;
    modport master (output i_run, tick_sec_u, tick_sec_d, tick_min_u, tick_min_d, tick_hour_u, tick_hour_d,
                    input o_msec, o_sec, o_min, o_hour, o_pm);
    modport slave  (input i_run, tick_sec_u, tick_sec_d, tick_min_u, tick_min_d, tick_hour_u, tick_hour_d,
                    output o_msec, o_sec, o_min, o_hour, o_pm);
`else
    modport master (output i_run, tick_sec_u, tick_sec_d, tick_min_u, tick_min_d, tick_hour_u, tick_hour_d,
                    input o_msec, o_sec, o_min, o_hour);
    modport slave  (input i_run, tick_sec_u, tick_sec_d, tick_min_u, tick_min_d, tick_hour_u, tick_hour_d,
                    output o_msec, o_sec, o_min, o_hour);
`endif
endinterface

// File: rtl/watch_field_cnt.sv
// watch_field_cnt: one mod-MOD time field; ports clk, rst (async active-low), i_carry, i_up, i_down -> o_val, o_carry; adjust beats carry
module watch_field_cnt #(
    parameter int MOD  = 60,
    parameter int W    = 6,
    parameter int INIT = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_carry,
    input  logic         i_up,
    input  logic         i_down,
    output logic [W-1:0] o_val,
    output logic         o_carry
);
    logic [W-1:0] val_q, val_d;
    logic         at_max, at_zero, adj, inc, dec;
    assign at_max  = val_q == W'(MOD - 1);
    assign at_zero = val_q == '0;
    // up+down together cancel, so the carry is honoured in that case
    assign adj     = i_up ^ i_down;
    assign inc     = adj ? i_up : i_carry;
    assign dec     = adj & i_down;
    // an adjust swallows both the incoming carry and the outgoing one
    assign o_carry = i_carry & ~adj & at_max;
    always_comb begin
        val_d = inc ? (at_max ? '0 : val_q + W'(1)) :
                dec ? (at_zero ? W'(MOD - 1) : val_q - W'(1)) : val_q;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) val_q <= W'(INIT);
        else      val_q <= val_d;
    end
    assign o_val = val_q;
endmodule

// File: rtl/watch_dp.sv
// watch_dp: free-running cs/s/min/h clock with up/down field adjust; ports clk, rst (async active-low), bus (watch_dp_if.slave); WATCH_H12_EN adds 12-hour display and o_pm
module watch_dp
    import watch_pkg::*;
#(
    parameter int FCOUNT    = FCOUNT_DEF,
    parameter int HOUR_INIT = 12
) (
    input  logic     clk,
    input  logic     rst,
    watch_dp_if.slave bus
);
    localparam int PW = FCOUNT > 1 ? $clog2(FCOUNT) : 1;
    logic [PW-1:0]     pre_q, pre_d;
    logic              tick_q, tick_d, wrap;
    logic              c_msec, c_sec, c_min, hour_carry_unused;
    logic [HOUR_W-1:0] hour;
    assign wrap   = pre_q == PW'(FCOUNT - 1);
    // frozen prescaler keeps its partial period
    assign pre_d  = !bus.i_run ? pre_q : wrap ? '0 : pre_q + PW'(1);
    assign tick_d = bus.i_run & wrap;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            tick_q <= tick_d;
        end
    end
    watch_field_cnt #(.MOD(MSEC_MOD), .W(MSEC_W), .INIT(0)) u_msec (
        .clk(clk), .rst(rst), .i_carry(tick_q), .i_up(1'b0), .i_down(1'b0),
        .o_val(bus.o_msec), .o_carry(c_msec));
    watch_field_cnt #(.MOD(SEC_MOD), .W(SEC_W), .INIT(0)) u_sec (
        .clk(clk), .rst(rst), .i_carry(c_msec), .i_up(bus.tick_sec_u), .i_down(bus.tick_sec_d),
        .o_val(bus.o_sec), .o_carry(c_sec));
    watch_field_cnt #(.MOD(MIN_MOD), .W(MIN_W), .INIT(0)) u_min (
        .clk(clk), .rst(rst), .i_carry(c_sec), .i_up(bus.tick_min_u), .i_down(bus.tick_min_d),
        .o_val(bus.o_min), .o_carry(c_min));
    watch_field_cnt #(.MOD(HOUR_MOD), .W(HOUR_W), .INIT(HOUR_INIT)) u_hour (
        .clk(clk), .rst(rst), .i_carry(c_min), .i_up(bus.tick_hour_u), .i_down(bus.tick_hour_d),
        .o_val(hour), .o_carry(hour_carry_unused));
`ifdef WATCH_H12_EN
    // display only: the internal count stays 0..23
    assign bus.o_hour = hour == '0 ? HOUR_W'(12) : hour > HOUR_W'(12) ? hour - HOUR_W'(12) : hour;
    assign bus.o_pm   = hour >= HOUR_W'(12);
`else
    assign bus.o_hour = hour;
`endif
endmodule

// File: tb/tb_watch_dp.sv
// tb_watch_dp: directed table-driven and sequence checks of watch_dp with FCOUNT=4
module tb_watch_dp;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad = 0;
    watch_dp_if bus();
    watch_dp #(.FCOUNT(4), .HOUR_INIT(12)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] adj;
        int         sec;
        int         min;
        int         hour;
    } vec_t;
    vec_t vecs[12];

    function automatic int disp_hour(int h);
`ifdef WATCH_H12_EN
        return h == 0 ? 12 : h > 12 ? h - 12 : h;
`else
        return h;
`endif
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_time(input string name, input int ms, input int s, input int m, input int h);
        chk({name, ".msec"}, int'(bus.o_msec), ms);
        chk({name, ".sec"}, int'(bus.o_sec), s);
        chk({name, ".min"}, int'(bus.o_min), m);
        chk({name, ".hour"}, int'(bus.o_hour), disp_hour(h));
    endtask

    // bits: {sec_u, sec_d, min_u, min_d, hour_u, hour_d}
    task automatic drive(input logic [5:0] a);
        {bus.tick_sec_u, bus.tick_sec_d, bus.tick_min_u, bus.tick_min_d, bus.tick_hour_u, bus.tick_hour_d} = a;
    endtask

    task automatic adj(input logic [5:0] a);
        drive(a);
        @(negedge clk);
        drive(6'b0);
    endtask

    task automatic do_reset();
        bus.i_run = 1'b0;
        drive(6'b0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        vecs[0]  = '{6'b100000, 1, 0, 12};
        vecs[1]  = '{6'b010000, 0, 0, 12};
        vecs[2]  = '{6'b010000, 59, 0, 12};
        vecs[3]  = '{6'b100000, 0, 0, 12};
        vecs[4]  = '{6'b000100, 0, 59, 12};
        vecs[5]  = '{6'b001100, 0, 59, 12};
        vecs[6]  = '{6'b000010, 0, 59, 13};
        vecs[7]  = '{6'b000011, 0, 59, 13};
        vecs[8]  = '{6'b000001, 0, 59, 12};
        vecs[9]  = '{6'b101010, 1, 0, 13};
        vecs[10] = '{6'b010101, 0, 59, 12};
        vecs[11] = '{6'b110000, 0, 59, 12};

        // reset values
        do_reset();
        chk_time("reset", 0, 0, 0, 12);

        // adjust table with time frozen
        foreach (vecs[i]) begin
            adj(vecs[i].adj);
            chk($sformatf("vec%0d.sec", i), int'(bus.o_sec), vecs[i].sec);
            chk($sformatf("vec%0d.min", i), int'(bus.o_min), vecs[i].min);
            chk($sformatf("vec%0d.hour", i), int'(bus.o_hour), disp_hour(vecs[i].hour));
            chk($sformatf("vec%0d.msec", i), int'(bus.o_msec), 0);
        end

        // hour 0 down wraps to 23
        repeat (12) adj(6'b000001);
        chk("hour0", int'(bus.o_hour), disp_hour(0));
`ifdef WATCH_H12_EN
        chk("pm0", int'(bus.o_pm), 0);
`endif
        adj(6'b000001);
        chk("hour_d_wrap", int'(bus.o_hour), disp_hour(23));

        // free run: msec steps every 4 cycles, sec carries on msec 99->0
        do_reset();
        bus.i_run = 1'b1;
        for (int n = 1; n <= 404; n++) begin
            @(negedge clk);
            chk($sformatf("run%0d.msec", n), int'(bus.o_msec), ((n - 1) / 4) % 100);
            chk($sformatf("run%0d.sec", n), int'(bus.o_sec), (n - 1) / 400);
        end

        // full rollover 23:59:59.99 -> 00:00:00.00 in one edge
        do_reset();
        adj(6'b010101);
        repeat (12) adj(6'b000010);
        chk_time("preload", 0, 59, 59, 23);
        bus.i_run = 1'b1;
        for (int n = 1; n <= 401; n++) begin
            @(negedge clk);
            if (n <= 400) chk_time($sformatf("roll%0d", n), (n - 1) / 4, 59, 59, 23);
            else          chk_time("rollover", 0, 0, 0, 0);
        end

        // sec down in the same cycle as the msec carry: adjust wins
        do_reset();
        repeat (10) adj(6'b100000);
        chk("sec10", int'(bus.o_sec), 10);
        bus.i_run = 1'b1;
        repeat (400) @(negedge clk);
        chk("pre_carry.msec", int'(bus.o_msec), 99);
        adj(6'b010000);
        chk_time("adj_vs_carry", 0, 9, 0, 12);

        // freeze mid-period, resume continues the partial period
        do_reset();
        bus.i_run = 1'b1;
        repeat (6) @(negedge clk);
        bus.i_run = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (n == 0 || n == 49) chk($sformatf("frozen%0d", n), int'(bus.o_msec), 1);
        end
        bus.i_run = 1'b1;
        @(negedge clk);
        chk("resume1", int'(bus.o_msec), 1);
        @(negedge clk);
        chk("resume2", int'(bus.o_msec), 1);
        @(negedge clk);
        chk("resume3", int'(bus.o_msec), 2);

        // async reset mid-count; pulses during reset are ignored
        adj(6'b101010);
        chk_time("pre_rst", 2, 1, 1, 13);
        #2 rst = 1'b0;
        #1 chk_time("async_rst", 0, 0, 0, 12);
        @(negedge clk);
        drive(6'b101010);
        @(negedge clk);
        drive(6'b0);
        chk_time("rst_hold", 0, 0, 0, 12);
        rst = 1'b1;
        bus.i_run = 1'b0;
        @(negedge clk);

`ifdef WATCH_H12_EN
        // 12-hour presentation
        chk("h12_pm12", int'(bus.o_pm), 1);
        chk("h12_hour12", int'(bus.o_hour), 12);
        adj(6'b000010);
        chk("h12_hour13", int'(bus.o_hour), 1);
        chk("h12_pm13", int'(bus.o_pm), 1);
        repeat (13) adj(6'b000001);
        chk("h12_hour0", int'(bus.o_hour), 12);
        chk("h12_pm0", int'(bus.o_pm), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
